// File: rtl/video_timing_pkg.sv
// Shared timing types, default 800x600@60 constants and axis-record helpers
// for the video timing generator.
package video_timing_pkg;

    // Storage width of one field in an axis record; wide enough for any CW in use.
    localparam int AXIS_W = 32;

    // Default mode: 800x600@60 with a 40 MHz dot clock.
    localparam int DEF_PCLK_HZ = 40_000_000;
    localparam int DEF_H_VIS   = 800;
    localparam int DEF_H_FP    = 40;
    localparam int DEF_H_SYNC  = 128;
    localparam int DEF_H_BP    = 88;
    localparam int DEF_V_VIS   = 600;
    localparam int DEF_V_FP    = 1;
    localparam int DEF_V_SYNC  = 4;
    localparam int DEF_V_BP    = 23;

    // One axis of timing; vis sits in the LSBs so the packed form is {bp,sync,fp,vis}.
    typedef struct packed {
        logic [AXIS_W-1:0] bp;
        logic [AXIS_W-1:0] sync;
        logic [AXIS_W-1:0] fp;
        logic [AXIS_W-1:0] vis;
    } axis_t;

    function automatic axis_t unpack_axis(input logic [4*AXIS_W-1:0] v);
        return axis_t'(v);
    endfunction

    function automatic logic [4*AXIS_W-1:0] pack_axis(input axis_t a);
        return {a.bp, a.sync, a.fp, a.vis};
    endfunction

    function automatic axis_t make_axis(input int vis, input int fp, input int sync, input int bp);
        axis_t a;
        a.vis  = AXIS_W'(unsigned'(vis));
        a.fp   = AXIS_W'(unsigned'(fp));
        a.sync = AXIS_W'(unsigned'(sync));
        a.bp   = AXIS_W'(unsigned'(bp));
        return a;
    endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// One axis counter (used for both H and V): counts enabled steps modulo the
// axis total, flags the wrap, and decodes visible/sync regions.
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic [CW+1:0] total,
    input  axis_t         tim,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          in_vis_nxt,
    output logic          in_sync
);

    localparam logic [CW+1:0] ONE_X = (CW+2)'(1);

    logic [CW+1:0] cnt_x;
    logic [CW+1:0] nxt_x;
    logic [CW+1:0] vis_x;
    logic [CW+1:0] sync_lo;
    logic [CW+1:0] sync_hi;
    logic [CW-1:0] count_nxt;
    logic          unused_tim;

    assign cnt_x   = (CW+2)'(count);
    assign vis_x   = (CW+2)'(tim.vis);
    assign sync_lo = vis_x + (CW+2)'(tim.fp);
    assign sync_hi = sync_lo + (CW+2)'(tim.sync);

    assign wrap      = step && (cnt_x == total - ONE_X);
    assign count_nxt = !step ? count : (wrap ? '0 : count + CW'(1));
    assign nxt_x     = (CW+2)'(count_nxt);

    // Visibility is judged on the position being loaded; sync on the one being left.
    assign in_vis_nxt = nxt_x < vis_x;
    assign in_sync    = (cnt_x >= sync_lo) && (cnt_x < sync_hi);

    // bp only matters through total; upper field bits are beyond CW.
    assign unused_tim = ^tim;

    // Position counter
    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else     count <= count_nxt;
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised video timing generator: next-pixel counters, lagged de/syncs,
// line/frame strobes and frame-boundary timing reconfiguration.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CW        = 16,
    parameter int H_VIS     = DEF_H_VIS,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VIS     = DEF_V_VIS,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    input  logic [4*CW-1:0] cfg_h,
    input  logic [4*CW-1:0] cfg_v,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          vis,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
);

    localparam logic  HS_ON = (HSYNC_POL != 0);
    localparam logic  VS_ON = (VSYNC_POL != 0);
    localparam axis_t DEF_H = make_axis(H_VIS, H_FP, H_SYNC, H_BP);
    localparam axis_t DEF_V = make_axis(V_VIS, V_FP, V_SYNC, V_BP);

    // Spread each CW-wide field of a config vector into the record layout.
    function automatic axis_t widen(input logic [4*CW-1:0] v);
        logic [4*AXIS_W-1:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w[i*AXIS_W +: AXIS_W] = AXIS_W'(v[i*CW +: CW]);
        return unpack_axis(w);
    endfunction

    function automatic logic [CW+1:0] total(input axis_t a);
        return (CW+2)'(a.vis) + (CW+2)'(a.fp) + (CW+2)'(a.sync) + (CW+2)'(a.bp);
    endfunction

    axis_t         act_h, act_v, pend_h, pend_v;
    logic          pend_full;
    logic [CW+1:0] ht, vt;
    logic          h_wrap, v_wrap;
    logic          h_vis_nxt, v_vis_nxt;
    logic          h_sync, v_sync;

    assign ht        = total(act_h);
    assign vt        = total(act_v);
    assign cfg_ready = !pend_full;

    video_axis_counter #(.CW(CW)) u_h (
        .clk        (clk),
        .rst        (rst),
        .step       (pix_en),
        .total      (ht),
        .tim        (act_h),
        .count      (hcount),
        .wrap       (h_wrap),
        .in_vis_nxt (h_vis_nxt),
        .in_sync    (h_sync)
    );

    // The vertical axis steps once per enabled line wrap; its wrap is the frame wrap.
    video_axis_counter #(.CW(CW)) u_v (
        .clk        (clk),
        .rst        (rst),
        .step       (h_wrap),
        .total      (vt),
        .tim        (act_v),
        .count      (vcount),
        .wrap       (v_wrap),
        .in_vis_nxt (v_vis_nxt),
        .in_sync    (v_sync)
    );

    // Active/pending timing: accept into the slot, promote only on a frame wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_h     <= DEF_H;
            act_v     <= DEF_V;
            pend_full <= 1'b0;
        end else begin
            if (v_wrap && pend_full) begin
                act_h     <= pend_h;
                act_v     <= pend_v;
                pend_full <= 1'b0;
            end
            if (cfg_valid && !pend_full) begin
                pend_h    <= widen(cfg_h);
                pend_v    <= widen(cfg_v);
                pend_full <= 1'b1;
            end
        end
    end

    // Output stage: vis tracks the new position, de/syncs lag by one enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vis         <= 1'b1;
            de          <= 1'b0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            if (pix_en) begin
                vis   <= h_vis_nxt && v_vis_nxt;
                de    <= vis;
                hsync <= h_sync ? HS_ON : ~HS_ON;
                vsync <= v_sync ? VS_ON : ~VS_ON;
            end
        end
    end

endmodule
